bpu: RTL

Parametrised branch prediction unit for the fetch stage of the RV32I pipeline: a tagged BTB, a table of saturating direction counters with an optional global-history (gshare) index, and a compile-time return address stack. It supersedes the untagged-BTB plus fixed 2-bit bimodal pair.
- Lookup: driven from IF with the fetch PC; the prediction is registered and consumed in ID.
- Feedback: driven from EM when a control transfer resolves.

---
 rtl/bpu_pkg.sv | 37 +++
 rtl/bpu_ras.sv | 45 ++++
 rtl/bpu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types and helpers for the branch prediction unit.
// Kind encodings, FSM states, counter update and PC field extraction.
package bpu_pkg;

   typedef enum logic [1:0] {
      KIND_BRANCH = 2'd0,
      KIND_JUMP   = 2'd1,
      KIND_CALL   = 2'd2,
      KIND_RETURN = 2'd3
   } kind_e;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   // Saturating +/-1 of a cnt_w-bit counter, carried in a 32-bit container.
   function automatic logic [31:0] sat_next(input logic [31:0] cnt, input logic taken,
                                            input int unsigned cnt_w);
      logic [31:0] max_v;
      max_v = (32'd1 << cnt_w) - 32'd1;
      if (taken) begin
         return (cnt >= max_v) ? max_v : cnt + 32'd1;
      end
      return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
   endfunction

   function automatic logic [31:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
      return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
   endfunction

   function automatic logic [31:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w,
                                          input int unsigned tag_w);
      return 32'((pc >> (2 + idx_w)) & ((64'd1 << tag_w) - 64'd1));
   endfunction

endpackage

// File: rtl/bpu_ras.sv
// bpu_ras: circular return address stack; overflow overwrites the oldest entry,
// underflow wraps the pointer and leaves the contents stale.
module bpu_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_addr,
   output logic [XLEN-1:0] top
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] top_ptr;
   logic [XLEN-1:0]  stack_q [DEPTH];
   logic [XLEN-1:0]  stack_d [DEPTH];

   always_comb begin
      ptr_d   = ptr_q;
      stack_d = stack_q;
      if (push) begin
         stack_d[ptr_q] = push_addr;
         ptr_d          = ptr_q + 1'b1;
      end else if (pop) begin
         ptr_d = ptr_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         stack_q <= '{default: '0};
      end else begin
         ptr_q   <= ptr_d;
         stack_q <= stack_d;
      end
   end

   assign top_ptr = ptr_q - 1'b1;
   assign top     = stack_q[top_ptr];

endmodule

// File: rtl/bpu.sv
// bpu: tagged BTB plus saturating-counter PHT with optional gshare index.
// Define BPU_RAS_EN to add the return address stack; without it returns predict like jumps.
module bpu
   import bpu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int IDX_W     = 10,
   parameter int TAG_W     = 8,
   parameter int CNT_W     = 2,
   parameter int GHR_W     = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pred_oe,
   input  logic [XLEN-1:0]        pred_pc,
   output logic                   pred_taken,
   output logic [XLEN-1:0]        pred_target,
   output logic [IDX_W+CNT_W-1:0] pred_meta,
   input  logic                   fb_we,
   input  logic [XLEN-1:0]        fb_pc,
   input  logic                   fb_taken,
   input  logic [XLEN-1:0]        fb_target,
   input  logic [1:0]             fb_kind,
   input  logic [IDX_W+CNT_W-1:0] fb_meta,
   output logic                   busy
);
   localparam int ENTRIES  = 1 << IDX_W;
   localparam int GHR_BITS = (GHR_W > 0) ? GHR_W : 1;
   localparam logic [CNT_W-1:0] PHT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

   if (GHR_W > IDX_W || CNT_W < 2 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0)
   begin : g_bad_cfg
      $error("bpu: unsupported parameter combination");
   end

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       sweep_q, sweep_d;
   logic                   busy_q, busy_d;
   logic [GHR_BITS-1:0]    ghr_q, ghr_d;
   logic                   pred_taken_q, pred_taken_d;
   logic [XLEN-1:0]        pred_target_q, pred_target_d;
   logic [IDX_W+CNT_W-1:0] pred_meta_q, pred_meta_d;

   logic             btb_valid [ENTRIES];
   logic [TAG_W-1:0] btb_tag   [ENTRIES];
   logic [XLEN-1:0]  btb_tgt   [ENTRIES];
   kind_e            btb_kind  [ENTRIES];
   logic [CNT_W-1:0] pht       [ENTRIES];

   logic             run, fb_act;
   logic [IDX_W-1:0] fb_btb_idx, fb_pht_idx;
   logic [TAG_W-1:0] fb_tag;
   logic [CNT_W-1:0] fb_cnt, fb_cnt_next;

   assign run    = (state_q == ST_RUN);
   assign fb_act = run && fb_we;

   always_comb begin
      fb_btb_idx  = IDX_W'(pc_index(64'(fb_pc), IDX_W));
      fb_tag      = TAG_W'(pc_tag(64'(fb_pc), IDX_W, TAG_W));
      fb_pht_idx  = fb_meta[CNT_W +: IDX_W];
      fb_cnt      = fb_meta[CNT_W-1:0];
      fb_cnt_next = CNT_W'(sat_next(32'(fb_cnt), fb_taken, CNT_W));
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      ghr_d   = ghr_q;
      if (state_q == ST_INIT) begin
         sweep_d = sweep_q + 1'b1;
         if (sweep_q == '1) begin
            state_d = ST_RUN;
            sweep_d = sweep_q;
         end
      end else if (fb_we && fb_kind == KIND_BRANCH && GHR_W > 0) begin
         ghr_d = GHR_BITS'({ghr_q, fb_taken});
      end
      busy_d = (state_d == ST_INIT);
   end

   // Write port: the init sweep and resolved feedback share it; feedback is dropped during INIT.
   logic             btb_we, btb_wvalid, pht_we;
   logic [IDX_W-1:0] btb_widx, pht_widx;
   logic [CNT_W-1:0] pht_wdata;

   always_comb begin
      btb_we     = 1'b0;
      btb_wvalid = 1'b1;
      btb_widx   = fb_btb_idx;
      pht_we     = 1'b0;
      pht_widx   = fb_pht_idx;
      pht_wdata  = fb_cnt_next;
      if (state_q == ST_INIT) begin
         btb_we     = 1'b1;
         btb_wvalid = 1'b0;
         btb_widx   = sweep_q;
         pht_we     = 1'b1;
         pht_widx   = sweep_q;
         pht_wdata  = PHT_INIT;
      end else if (fb_we) begin
         btb_we = fb_taken;
         pht_we = (fb_kind == KIND_BRANCH);
      end
   end

   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_valid[btb_widx] <= btb_wvalid;
         btb_tag[btb_widx]   <= fb_tag;
         btb_tgt[btb_widx]   <= fb_target;
         btb_kind[btb_widx]  <= kind_e'(fb_kind);
      end
      if (pht_we) begin
         pht[pht_widx] <= pht_wdata;
      end
   end

`ifdef BPU_RAS_EN
   logic [XLEN-1:0] ras_top;

   bpu_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (fb_act && fb_kind == KIND_CALL),
      .pop       (fb_act && fb_kind == KIND_RETURN),
      .push_addr (fb_pc + XLEN'(4)),
      .top       (ras_top)
   );
`endif

   logic [IDX_W-1:0] lk_btb_idx, lk_pht_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [CNT_W-1:0] lk_cnt;
   logic [XLEN-1:0]  lk_target;
   logic             lk_hit;
   kind_e            lk_kind;

   always_comb begin
      lk_btb_idx = IDX_W'(pc_index(64'(pred_pc), IDX_W));
      lk_tag     = TAG_W'(pc_tag(64'(pred_pc), IDX_W, TAG_W));
      lk_pht_idx = lk_btb_idx ^ IDX_W'(ghr_q);
      lk_hit     = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
      lk_kind    = btb_kind[lk_btb_idx];
      lk_cnt     = pht[lk_pht_idx];
      lk_target  = btb_tgt[lk_btb_idx];
`ifdef BPU_RAS_EN
      if (lk_hit && lk_kind == KIND_RETURN) begin
         lk_target = ras_top;
      end
`endif
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      pred_meta_d   = pred_meta_q;
      if (pred_oe) begin
         pred_taken_d  = run && lk_hit && (lk_kind != KIND_BRANCH || lk_cnt[CNT_W-1]);
         pred_target_d = {lk_target[XLEN-1:1], 1'b0};
         pred_meta_d   = {lk_pht_idx, lk_cnt};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_INIT;
         sweep_q       <= '0;
         busy_q        <= 1'b1;
         ghr_q         <= '0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         pred_meta_q   <= '0;
      end else begin
         state_q       <= state_d;
         sweep_q       <= sweep_d;
         busy_q        <= busy_d;
         ghr_q         <= ghr_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         pred_meta_q   <= pred_meta_d;
      end
   end

   assign pred_taken  = pred_taken_q;
   assign pred_target = pred_target_q;
   assign pred_meta   = pred_meta_q;
   assign busy        = busy_q;

endmodule
